// File: rtl/ats21_pkg.sv
// ============================================================================
// ats21_pkg : shared types and field positions for the ATS21 sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package ats21_pkg;

   typedef enum logic [2:0] {
      OP_NOP     = 3'b000,
      OP_SET_CLK = 3'b001,
      OP_EN_CLK  = 3'b010,
      OP_MODE    = 3'b011,
      OP_SET_ALM = 3'b101,
      OP_SET_TMR = 3'b110,
      OP_EN_ALM  = 3'b111
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEND_HI = 3'd1,
      ST_SEND_LO = 3'd2,
      ST_WAIT    = 3'd3,
      ST_RESP    = 3'd4
   } state_e;

   localparam int c_OP_MSB  = 31;
   localparam int c_OP_LSB  = 29;
   localparam int c_CLK_MSB = 28;
   localparam int c_CLK_LSB = 25;
   localparam int c_ALM_MSB = 28;
   localparam int c_ALM_LSB = 24;

endpackage

`default_nettype wire

// File: rtl/ats21_conflict_check.sv
// ============================================================================
// ats21_conflict_check : flags two ATS21 commands that target the same resource
// Rev 1.0
// ============================================================================
`default_nettype none

module ats21_conflict_check
   import ats21_pkg::*;
(
   input  logic [31:0] cmd_a_i,
   input  logic [31:0] cmd_b_i,
   output logic        conflict_o
);

   logic [2:0] op_a_w, op_b_w;
   logic       clk_a_w, clk_b_w, alm_a_w, alm_b_w;
   logic       unused_w;

   assign op_a_w  = cmd_a_i[c_OP_MSB:c_OP_LSB];
   assign op_b_w  = cmd_b_i[c_OP_MSB:c_OP_LSB];
   assign clk_a_w = (op_a_w == OP_SET_CLK) || (op_a_w == OP_EN_CLK);
   assign clk_b_w = (op_b_w == OP_SET_CLK) || (op_b_w == OP_EN_CLK);
   assign alm_a_w = op_a_w inside {OP_SET_ALM, OP_SET_TMR, OP_EN_ALM};
   assign alm_b_w = op_b_w inside {OP_SET_ALM, OP_SET_TMR, OP_EN_ALM};

   // Payload bits never take part in resource matching.
   assign unused_w = ^{cmd_a_i[23:0], cmd_b_i[23:0]};

   assign conflict_o =
        (clk_a_w && clk_b_w &&
         (cmd_a_i[c_CLK_MSB:c_CLK_LSB] == cmd_b_i[c_CLK_MSB:c_CLK_LSB]))
     || (alm_a_w && alm_b_w &&
         (cmd_a_i[c_ALM_MSB:c_ALM_LSB] == cmd_b_i[c_ALM_MSB:c_ALM_LSB]))
     || ((op_a_w == OP_MODE) && (op_b_w == OP_MODE));

endmodule

`default_nettype wire

// File: rtl/ats21_sequencer.sv
// ============================================================================
// ats21_sequencer : two-client round-robin issuer of 32-bit ATS21 instructions
// Rev 1.0
// ============================================================================
`default_nettype none

module ats21_sequencer
   import ats21_pkg::*;
#(
   parameter int   STAT_WAIT = 1,
   parameter logic A_FIRST   = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        a_cmd_valid_i,
   input  logic [31:0] a_cmd_i,
   input  logic        b_cmd_valid_i,
   input  logic [31:0] b_cmd_i,
   output logic        a_cmd_ready_o,
   output logic        b_cmd_ready_o,
   output logic        a_rsp_valid_o,
   output logic        b_rsp_valid_o,
   output logic        a_rsp_ack_o,
   output logic        b_rsp_ack_o,
   output logic        ats_req_o,
   output logic [15:0] ats_ctrlA_o,
   output logic [15:0] ats_ctrlB_o,
   input  logic [1:0]  ats_stat_i,
   output logic        busy_o
);

   logic [1:0]  rst_sync_q;
   logic        rst_n_w;
   state_e      state_q;
   logic        ptr_q;
   logic [31:0] cmd_a_q, cmd_b_q;
   logic        acc_a_q, acc_b_q;
   logic [2:0]  wait_cnt_q;
   logic [1:0]  stat_q;
   logic        ats_req_q, a_rsp_valid_q, b_rsp_valid_q, a_rsp_ack_q, b_rsp_ack_q;
   logic [15:0] lane_a_q, lane_b_q;
   logic        conflict_w, clash_w, sel_a_w, sel_b_w, all_nop_w, nop_a_w, nop_b_w;

   // Reset asserts immediately but releases two clocks later.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) rst_sync_q <= 2'b00;
      else            rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_w = rst_sync_q[1];

   ats21_conflict_check u_conflict (
      .cmd_a_i    (a_cmd_i),
      .cmd_b_i    (b_cmd_i),
      .conflict_o (conflict_w)
   );

   assign clash_w   = a_cmd_valid_i && b_cmd_valid_i && conflict_w;
   assign sel_a_w   = a_cmd_valid_i && (!clash_w ||  ptr_q);
   assign sel_b_w   = b_cmd_valid_i && (!clash_w || !ptr_q);
   assign all_nop_w = (!sel_a_w || (a_cmd_i[c_OP_MSB:c_OP_LSB] == OP_NOP))
                   && (!sel_b_w || (b_cmd_i[c_OP_MSB:c_OP_LSB] == OP_NOP));
   assign nop_a_w   = (cmd_a_q[c_OP_MSB:c_OP_LSB] == OP_NOP);
   assign nop_b_w   = (cmd_b_q[c_OP_MSB:c_OP_LSB] == OP_NOP);

   assign a_cmd_ready_o = rst_n_w && (state_q == ST_IDLE) && sel_a_w;
   assign b_cmd_ready_o = rst_n_w && (state_q == ST_IDLE) && sel_b_w;

   always_ff @(posedge clk_i or negedge rst_n_w) begin
      if (!rst_n_w) begin
         state_q       <= ST_IDLE;
         ptr_q         <= A_FIRST;
         cmd_a_q       <= '0;
         cmd_b_q       <= '0;
         acc_a_q       <= 1'b0;
         acc_b_q       <= 1'b0;
         wait_cnt_q    <= '0;
         stat_q        <= '0;
         ats_req_q     <= 1'b0;
         lane_a_q      <= '0;
         lane_b_q      <= '0;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
         a_rsp_ack_q   <= 1'b0;
         b_rsp_ack_q   <= 1'b0;
      end else begin
         ats_req_q     <= 1'b0;
         lane_a_q      <= '0;
         lane_b_q      <= '0;
         a_rsp_valid_q <= 1'b0;
         b_rsp_valid_q <= 1'b0;
         a_rsp_ack_q   <= 1'b0;
         b_rsp_ack_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (sel_a_w || sel_b_w) begin
                  cmd_a_q <= sel_a_w ? a_cmd_i : '0;
                  cmd_b_q <= sel_b_w ? b_cmd_i : '0;
                  acc_a_q <= sel_a_w;
                  acc_b_q <= sel_b_w;
                  if (clash_w) ptr_q <= ~ptr_q;
                  state_q <= all_nop_w ? ST_RESP : ST_SEND_HI;
               end
            end
            ST_SEND_HI: begin
               ats_req_q <= 1'b1;
               lane_a_q  <= cmd_a_q[31:16];
               lane_b_q  <= cmd_b_q[31:16];
               state_q   <= ST_SEND_LO;
            end
            ST_SEND_LO: begin
               lane_a_q   <= cmd_a_q[15:0];
               lane_b_q   <= cmd_b_q[15:0];
               wait_cnt_q <= 3'(STAT_WAIT - 1);
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt_q == 3'd0) begin
                  stat_q  <= ats_stat_i;
                  state_q <= ST_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 3'd1;
               end
            end
            ST_RESP: begin
               a_rsp_valid_q <= acc_a_q;
               b_rsp_valid_q <= acc_b_q;
               a_rsp_ack_q   <= acc_a_q && (nop_a_w || stat_q[0]);
               b_rsp_ack_q   <= acc_b_q && (nop_b_w || stat_q[1]);
               state_q       <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign ats_req_o     = ats_req_q;
   assign ats_ctrlA_o   = lane_a_q;
   assign ats_ctrlB_o   = lane_b_q;
   assign a_rsp_valid_o = a_rsp_valid_q;
   assign b_rsp_valid_o = b_rsp_valid_q;
   assign a_rsp_ack_o   = a_rsp_ack_q;
   assign b_rsp_ack_o   = b_rsp_ack_q;
   assign busy_o        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ats21_sequencer.sv
// ============================================================================
// tb_ats21_sequencer : directed vector bench for ats21_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ats21_sequencer;

   localparam int STAT_WAIT = 1;
   localparam int LAT_FULL  = 4 + STAT_WAIT;
   localparam int LAT_NOP   = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [31:0] a_cmd = '0, b_cmd = '0;
   logic [1:0]  stat = 2'b00;
   logic        a_ready, b_ready, a_rv, b_rv, a_ack, b_ack, req, busy;
   logic [15:0] ctrl_a, ctrl_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ats21_sequencer #(.STAT_WAIT(STAT_WAIT), .A_FIRST(1'b1)) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .a_cmd_valid_i (a_valid),
      .a_cmd_i       (a_cmd),
      .b_cmd_valid_i (b_valid),
      .b_cmd_i       (b_cmd),
      .a_cmd_ready_o (a_ready),
      .b_cmd_ready_o (b_ready),
      .a_rsp_valid_o (a_rv),
      .b_rsp_valid_o (b_rv),
      .a_rsp_ack_o   (a_ack),
      .b_rsp_ack_o   (b_ack),
      .ats_req_o     (req),
      .ats_ctrlA_o   (ctrl_a),
      .ats_ctrlB_o   (ctrl_b),
      .ats_stat_i    (stat),
      .busy_o        (busy)
   );

   typedef struct {
      logic        av;  logic [31:0] ac;
      logic        bv;  logic [31:0] bc;
      logic [1:0]  st;
      logic        rdy_a, rdy_b;
      int          req_n;
      logic [15:0] a_hi, a_lo, b_hi, b_lo;
      int          lat;
      logic        rv_a, rv_b, ack_a, ack_b;
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mk(logic av, logic [31:0] ac, logic bv, logic [31:0] bc,
                               logic [1:0] st, logic ra, logic rb, int rn,
                               logic [15:0] ah, logic [15:0] al, logic [15:0] bh,
                               logic [15:0] bl, int lat, logic va, logic vb,
                               logic ka, logic kb);
      vec_t v;
      v.av = av; v.ac = ac; v.bv = bv; v.bc = bc; v.st = st;
      v.rdy_a = ra; v.rdy_b = rb; v.req_n = rn;
      v.a_hi = ah; v.a_lo = al; v.b_hi = bh; v.b_lo = bl;
      v.lat = lat; v.rv_a = va; v.rv_b = vb; v.ack_a = ka; v.ack_b = kb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int          req_n, rsp_n, rsp_k;
      logic [15:0] ah, al, bh, bl;
      logic        va, vb, ka, kb;
      string       tag;
      req_n = 0; rsp_n = 0; rsp_k = 0;
      ah = '0; al = '0; bh = '0; bl = '0;
      va = 0; vb = 0; ka = 0; kb = 0;
      tag = $sformatf("v%0d", id);
      wait_idle();
      a_valid = v.av; a_cmd = v.ac; b_valid = v.bv; b_cmd = v.bc; stat = v.st;
      #1;
      chk({tag, "_ready_a"}, 64'(a_ready), 64'(v.rdy_a));
      chk({tag, "_ready_b"}, 64'(b_ready), 64'(v.rdy_b));
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) begin
            // Commands change while not ready; the transaction must ignore them.
            a_valid = 1'b0; b_valid = 1'b0;
            a_cmd = 32'hFFFF_FFFF; b_cmd = 32'hFFFF_FFFF;
         end
         if (req) req_n++;
         if (k == 2) begin ah = ctrl_a; bh = ctrl_b; end
         if (k == 3) begin al = ctrl_a; bl = ctrl_b; end
         if (a_rv || b_rv) begin
            rsp_n++;
            if (rsp_k == 0) begin
               rsp_k = k; va = a_rv; vb = b_rv; ka = a_ack; kb = b_ack;
            end
         end
      end
      chk({tag, "_req_cycles"}, 64'(req_n), 64'(v.req_n));
      chk({tag, "_laneA_hi"}, 64'(ah), 64'(v.a_hi));
      chk({tag, "_laneA_lo"}, 64'(al), 64'(v.a_lo));
      chk({tag, "_laneB_hi"}, 64'(bh), 64'(v.b_hi));
      chk({tag, "_laneB_lo"}, 64'(bl), 64'(v.b_lo));
      chk({tag, "_rsp_latency"}, 64'(rsp_k), 64'(v.lat));
      chk({tag, "_rsp_cycles"}, 64'(rsp_n), 64'd1);
      chk({tag, "_rsp_valid"}, {62'd0, va, vb}, {62'd0, v.rv_a, v.rv_b});
      chk({tag, "_rsp_ack"}, {62'd0, ka, kb}, {62'd0, v.ack_a, v.ack_b});
   endtask

   function automatic logic [63:0] outs();
      return {27'd0, req, ctrl_a, ctrl_b, busy, a_rv, b_rv, a_ack, b_ack, a_ready, b_ready};
   endfunction

   initial begin
      logic [15:0] rdy_seen;
      int          rsp_seen;

      vecs[0] = mk(1, 32'h2200_0005, 0, 32'h0, 2'b01, 1, 0, 1, 16'h2200, 16'h0005, 0, 0, LAT_FULL, 1, 0, 1, 0);
      vecs[1] = mk(1, 32'hA100_0010, 1, 32'hA100_0020, 2'b11, 1, 0, 1, 16'hA100, 16'h0010, 0, 0, LAT_FULL, 1, 0, 1, 0);
      vecs[2] = mk(0, 32'hA100_0010, 1, 32'hA100_0020, 2'b11, 0, 1, 1, 0, 0, 16'hA100, 16'h0020, LAT_FULL, 0, 1, 0, 1);
      vecs[3] = mk(1, 32'hA100_0030, 1, 32'hA100_0040, 2'b11, 0, 1, 1, 0, 0, 16'hA100, 16'h0040, LAT_FULL, 0, 1, 0, 1);
      vecs[4] = mk(1, 32'h2400_0001, 1, 32'hA300_0002, 2'b11, 1, 1, 1, 16'h2400, 16'h0001, 16'hA300, 16'h0002, LAT_FULL, 1, 1, 1, 1);
      vecs[5] = mk(1, 32'h0000_0000, 0, 32'h0, 2'b00, 1, 0, 0, 0, 0, 0, 0, LAT_NOP, 1, 0, 1, 0);
      vecs[6] = mk(1, 32'h2400_0001, 1, 32'hA300_0002, 2'b10, 1, 1, 1, 16'h2400, 16'h0001, 16'hA300, 16'h0002, LAT_FULL, 1, 1, 0, 1);
      vecs[7] = mk(1, 32'h6000_0001, 1, 32'h6000_0002, 2'b01, 1, 0, 1, 16'h6000, 16'h0001, 0, 0, LAT_FULL, 1, 0, 1, 0);
      vecs[8] = mk(1, 32'h2200_0000, 1, 32'h4200_0000, 2'b11, 0, 1, 1, 0, 0, 16'h4200, 16'h0000, LAT_FULL, 0, 1, 0, 1);
      vecs[9] = mk(1, 32'h0000_0000, 1, 32'hA300_0002, 2'b00, 1, 1, 1, 0, 0, 16'hA300, 16'h0002, LAT_FULL, 1, 1, 1, 0);

      // Reset state, with a pending command that must not be readied.
      a_valid = 1'b1; a_cmd = 32'h2200_0005;
      #12;
      chk("reset_outputs", outs(), 64'd0);
      a_valid = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Back-to-back: a held command is re-accepted every 4+STAT_WAIT cycles.
      wait_idle();
      a_valid = 1'b1; a_cmd = 32'h2200_0005; stat = 2'b01;
      rdy_seen = '0;
      for (int n = 0; n < 16; n++) begin
         #1;
         rdy_seen[n] = a_ready;
         @(negedge clk);
      end
      a_valid = 1'b0;
      chk("issue_spacing", 64'(rdy_seen), 64'h8421);

      // Leaves the pointer at B so reset must restore it.
      run_vec(vecs[1], 11);

      // Reset during WAIT aborts silently.
      wait_idle();
      a_valid = 1'b1; a_cmd = 32'h2200_0005; stat = 2'b01;
      @(posedge clk);
      @(negedge clk); a_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      a_valid = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("midreset_outputs", outs(), 64'd0);
      a_valid = 1'b0;
      rsp_seen = 0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         if (a_rv || b_rv || req || busy) rsp_seen++;
      end
      reset_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (a_rv || b_rv || req || busy) rsp_seen++;
      end
      chk("abort_no_activity", 64'(rsp_seen), 64'd0);
      run_vec(vecs[0], 20);
      run_vec(vecs[1], 21);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
